// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths, FSM encoding and the latched request.
package apb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // Transfer attributes captured in the setup cycle
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // True when a word address maps onto an implemented register
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return ({1'b0, addr} < (ADDR_W + 1)'(depth));
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage: one synchronous write port, one combinational read port, async clear.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Caller guarantees addresses are in range before asserting we_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[IDX_W'(waddr_i)] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[IDX_W'(raddr_i)];

endmodule

// File: rtl/apb_slave.sv
// APB register slave with a fixed number of wait states, latched request and range-checked access.
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  apb_req_t          req_q, req_d;
  logic              commit_c;
  logic              in_range_c;
  logic [DATA_W-1:0] rdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
    end
  end

  // Next state; dropping psel before completion abandons the transfer without a commit
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    req_d    = req_q;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d     = SETUP;
          req_d.addr  = paddr;
          req_d.write = pwrite;
          req_d.wdata = pwdata;
        end
      end
      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
          wcnt_d  = WCNT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d  = IDLE;
          commit_c = req_q.write && in_range_c;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  assign in_range_c = addr_in_range(req_q.addr, DEPTH);

  apb_slave_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (commit_c),
    .waddr_i (req_q.addr),
    .wdata_i (req_q.wdata),
    .raddr_i (req_q.addr),
    .rdata_o (rdata_c)
  );

  // Response decoded from registered state only
  assign pready  = (state_q == ACCESS) && (wcnt_q == '0);
  assign pslverr = pready && !in_range_c;
  assign prdata  = (pready && !req_q.write && in_range_c) ? rdata_c : '0;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances with WAIT_CYCLES 1, 0 and 3 on a shared bus.
module tb_apb_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=3
  apb_slave #(.WAIT_CYCLES(1), .DEPTH(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]),
    .pslverr(pslverr_v[0]));
  apb_slave #(.WAIT_CYCLES(0), .DEPTH(16)) u_w0 (
    .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]),
    .pslverr(pslverr_v[1]));
  apb_slave #(.WAIT_CYCLES(3), .DEPTH(16)) u_w3 (
    .clk(clk), .rst_n(rst_n), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2]),
    .pslverr(pslverr_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts in the cycle after an edge; returns one cycle after completion (back-to-back ready)
  task automatic xfer(input int d, input logic wr, input logic [4:0] a, input logic [31:0] wd,
                      input bit mangle, output logic [31:0] rd, output logic err,
                      output int lat);
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (mangle) begin
      paddr = ~a; pwdata = ~wd; pwrite = ~wr;
    end
    lat = 1;
    while (!pready_v[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = prdata_v[d];
    err = pslverr_v[d];
    if (!pready_v[d]) chk($sformatf("timeout_dut%0d", d), 32'(pready_v[d]), 32'd1);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input int d, input logic [4:0] a,
                        input logic [31:0] wd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(d, 1'b1, a, wd, 1'b0, rd, err, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input int d, input logic [4:0] a,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(d, 1'b0, a, 32'h0, 1'b0, rd, err, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        seen;

    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready%0d", d), 32'(pready_v[d]), 32'd0);
      chk($sformatf("rst_pslverr%0d", d), 32'(pslverr_v[d]), 32'd0);
      chk($sformatf("rst_prdata%0d", d), prdata_v[d], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read with one wait state: pready in the 3rd access-phase cycle
    wr_chk("w1_wr3", 0, 5'd3, 32'hDEADBEEF, 1'b0, 3);
    rd_chk("w1_rd3", 0, 5'd3, 32'hDEADBEEF, 1'b0, 3);

    // Zero wait states, back-to-back writes then reads
    for (int i = 0; i < 4; i++)
      wr_chk($sformatf("b2b_wr%0d", i), 1, 5'(i), 32'hC0DE0000 + 32'(i), 1'b0, 2);
    for (int i = 0; i < 4; i++)
      rd_chk($sformatf("b2b_rd%0d", i), 1, 5'(i), 32'hC0DE0000 + 32'(i), 1'b0, 2);

    // Out-of-range write errors and must not alias onto a low register
    wr_chk("oor_wr20", 0, 5'd20, 32'h12345678, 1'b1, 3);
    rd_chk("oor_rd4", 0, 5'd4, 32'h0, 1'b0, 3);
    rd_chk("oor_rd20", 0, 5'd20, 32'h0, 1'b1, 3);
    wr_chk("edge_wr15", 0, 5'd15, 32'hF00DCAFE, 1'b0, 3);
    rd_chk("edge_rd15", 0, 5'd15, 32'hF00DCAFE, 1'b0, 3);
    rd_chk("edge_rd16", 0, 5'd16, 32'h0, 1'b1, 3);

    // Three wait states: normal write/read, then an aborted write to address 7
    wr_chk("w3_wr6", 2, 5'd6, 32'h600D600D, 1'b0, 5);
    rd_chk("w3_rd6", 2, 5'd6, 32'h600D600D, 1'b0, 5);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd7; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = pready_v[2];
    @(posedge clk); #1;
    seen |= pready_v[2];
    psel[2] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= pready_v[2];
    end
    penable = 1'b0;
    chk("abort_pready", 32'(seen), 32'd0);
    rd_chk("abort_rd7", 2, 5'd7, 32'h0, 1'b0, 5);

    // penable without a setup cycle is ignored
    psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'd1; pwdata = 32'hFFFFFFFF;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= pready_v[1];
    end
    psel[1] = 1'b0; penable = 1'b0;
    chk("nosetup_pready", 32'(seen), 32'd0);
    rd_chk("nosetup_rd1", 1, 5'd1, 32'hC0DE0001, 1'b0, 2);

    // Master changes address, data and direction after the setup cycle
    xfer(0, 1'b1, 5'd2, 32'h0BADF00D, 1'b1, rd, err, lat);
    chk("mangle_lat", 32'(lat), 32'd3);
    chk("mangle_err", 32'(err), 32'd0);
    rd_chk("mangle_rd2", 0, 5'd2, 32'h0BADF00D, 1'b0, 3);
    rd_chk("mangle_rd29", 0, 5'd29, 32'h0, 1'b1, 3);

    // Reset in the completion cycle of a write to address 5
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd5; pwdata = 32'h55AA55AA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_pready_pre", 32'(pready_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_pready", 32'(pready_v[0]), 32'd0);
    chk("rstmid_pslverr", 32'(pslverr_v[0]), 32'd0);
    chk("rstmid_prdata", prdata_v[0], 32'd0);
    psel[0] = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rstmid_rd5", 0, 5'd5, 32'h0, 1'b0, 3);
    rd_chk("rstmid_rd3", 0, 5'd3, 32'h0, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
